// File: rtl/mat2x2_stream_mult_if.sv
// Operand/result stream bundle for mat2x2_stream_mult.
interface mat2x2_stream_mult_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, ovf
  );
endinterface

// File: rtl/mat2x2_stream_mult.sv
// Streaming 2x2 signed matrix multiply with one shared 32x32 multiplier.
// MAT_SAT_EN: clamp out-of-range elements instead of wrapping to 32 bits.
module mat2x2_stream_mult (
  input  logic               clk,
  input  logic               rst,
  mat2x2_stream_mult_if.slave bus
);
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [7:0][31:0] ops;
  logic [3:0][31:0] res;
  logic [65:0]      acc, acc_next;
  logic [31:0]      mul_a, mul_b, narrow;
  logic [63:0]      prod;
  logic             oor, in_fire, out_fire;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // ops[7] is A00 and ops[0] is B11; in COMPUTE cnt = {i,j,k}.
  always_comb begin
    mul_a    = ops[3'd7 - {1'b0, cnt[2], cnt[0]}];
    mul_b    = ops[3'd3 - {1'b0, cnt[0], cnt[1]}];
    prod     = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    acc_next = (cnt[0] ? acc : 66'd0) + {{2{prod[63]}}, prod};
    oor      = !((&acc_next[65:31]) || !(|acc_next[65:31]));
`ifdef MAT_SAT_EN
    narrow   = oor ? (acc_next[65] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_next[31:0];
`else
    narrow   = acc_next[31:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      cnt           <= '0;
      ops           <= '0;
      res           <= '0;
      acc           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          ops <= {ops[6:0], bus.in_data};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd0) bus.ovf <= 1'b0;
          if (cnt == 3'd7) begin
            state        <= COMPUTE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        COMPUTE: begin
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          // k=1 closes element (i,j)
          if (cnt[0]) begin
            res[cnt[2:1]] <= narrow;
            if (oor) bus.ovf <= 1'b1;
          end
          if (cnt == 3'd7) begin
            state         <= DRAIN;
            bus.out_valid <= 1'b1;
            bus.out_data  <= res[0];
          end
        end
        DRAIN: if (out_fire) begin
          if (cnt == 3'd3) begin
            state         <= LOAD;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            cnt          <= cnt + 3'd1;
            bus.out_data <= res[cnt[1:0] + 2'd1];
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mat2x2_stream_mult.sv
// Directed bench for mat2x2_stream_mult: basic, signed, overflow, stall, reset, back-to-back.
module tb_mat2x2_stream_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rx_cnt = 0;
  logic [31:0] got [4];
  logic [31:0] got1 [4];

  mat2x2_stream_mult_if bus();
  mat2x2_stream_mult dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [7:0][31:0] M_BASIC  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  localparam logic [7:0][31:0] M_SIGNED = {32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF,
                                           32'd3, 32'hFFFFFFFC, 32'd5, 32'd6};
  localparam logic [7:0][31:0] M_OVF    = {32'h7FFFFFFF, 32'd0, 32'd0, 32'd0,
                                           32'd2, 32'd0, 32'd0, 32'd0};
`ifdef MAT_SAT_EN
  localparam logic [31:0] OVF00 = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OVF00 = 32'hFFFFFFFE;
`endif
  localparam logic [31:0] E_BASIC  [4] = '{32'd19, 32'd22, 32'd43, 32'd50};
  localparam logic [31:0] E_SIGNED [4] = '{32'hFFFFFFFD, 32'd4, 32'hFFFFFFFB, 32'hFFFFFFFA};
  localparam logic [31:0] E_OVF    [4] = '{OVF00, 32'd0, 32'd0, 32'd0};

  // Called #1 after an edge; returns #1 after the accepting edge with in_valid still high.
  task automatic send_word(input logic [31:0] w);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready never rose for word %h", w);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pair(input logic [7:0][31:0] m, input bit hold);
    for (int i = 7; i >= 0; i--) send_word(m[i]);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic recv_words();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int t = 0;
      while (!bus.out_valid && t < 200) begin @(posedge clk); #1; t++; end
      if (t >= 200) begin
        n_cmp++; n_bad++;
        $display("FAIL recv_timeout: word %0d never valid", n);
      end
      got[n] = bus.out_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.out_data !== 32'd0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat = 0;
    send_pair(M_BASIC, 1'b0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready: got %b want 0", bus.in_ready); end
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL basic_latency: got %0d edges want 8", lat); end
    recv_words();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (got[n] !== E_BASIC[n]) begin n_bad++; $display("FAIL basic_res%0d: got %h want %h", n, got[n], E_BASIC[n]); end
    end
    n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", bus.ovf); end
  endtask

  task automatic test_signed();
    send_pair(M_SIGNED, 1'b0);
    recv_words();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (got[n] !== E_SIGNED[n]) begin n_bad++; $display("FAIL signed_res%0d: got %h want %h", n, got[n], E_SIGNED[n]); end
    end
  endtask

  task automatic test_overflow();
    send_pair(M_OVF, 1'b0);
    recv_words();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (got[n] !== E_OVF[n]) begin n_bad++; $display("FAIL ovf_res%0d: got %h want %h", n, got[n], E_OVF[n]); end
    end
    n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
  endtask

  task automatic test_backpressure();
    int t = 0;
    int n = 0;
    bit rdy = 1'b1;
    bus.out_ready = 1'b0;
    send_pair(M_BASIC, 1'b0);
    while (!bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (bus.out_data !== 32'd19) begin n_bad++; $display("FAIL bp_hold%0d: got %h want 13", c, bus.out_data); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want 0", c, bus.in_ready); end
      @(posedge clk); #1;
    end
    t = 0;
    while (n < 4 && t < 40) begin
      bus.out_ready = rdy;
      n_cmp++;
      if (!bus.out_valid) begin n_bad++; $display("FAIL bp_valid_drop: word %0d out_valid 0 want 1", n); end
      else begin
        if (bus.out_data !== E_BASIC[n]) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", n, bus.out_data, E_BASIC[n]); end
        if (rdy) n++;
      end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_drain: got %b want 0", bus.in_ready); end
      rdy = !rdy;
      @(posedge clk); #1; t++;
    end
    n_cmp++; if (n != 4) begin n_bad++; $display("FAIL bp_count: got %0d words want 4", n); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_extra_word: out_valid %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_end: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bit seen = 1'b0;
    for (int i = 7; i >= 3; i--) send_word(M_BASIC[i]);
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'd99;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_load: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy); end
    send_pair(M_SIGNED, 1'b0);
    bus.out_ready = 1'b1;
    while (!bus.out_valid && t < 50) begin @(posedge clk); #1; t++; end
    n_cmp++; if (bus.out_data !== E_SIGNED[0]) begin n_bad++; $display("FAIL rmid_w0: got %h want %h", bus.out_data, E_SIGNED[0]); end
    @(posedge clk); #1;
    n_cmp++; if (bus.out_data !== E_SIGNED[1]) begin n_bad++; $display("FAIL rmid_w1: got %h want %h", bus.out_data, E_SIGNED[1]); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 32'd0) begin n_bad++; $display("FAIL rmid_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready: got %b want 1", bus.in_ready); end
    repeat (12) begin
      if (bus.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rmid_spurious: out_valid seen 1 want 0"); end
    send_pair(M_BASIC, 1'b0);
    recv_words();
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (got[n] !== E_BASIC[n]) begin n_bad++; $display("FAIL rmid_res%0d: got %h want %h", n, got[n], E_BASIC[n]); end
    end
  endtask

  task automatic test_back_to_back();
    rx_cnt = 0;
    fork
      begin
        send_pair(M_OVF, 1'b1);
        send_word(M_BASIC[7]);
        n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf_clear: got %b want 0", bus.ovf); end
        n_cmp++; if (rx_cnt != 4) begin n_bad++; $display("FAIL b2b_stall: %0d words drained want 4", rx_cnt); end
        for (int i = 6; i >= 0; i--) send_word(M_BASIC[i]);
        bus.in_valid = 1'b0;
      end
      begin
        recv_words();
        rx_cnt = 4;
        n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL b2b_ovf_set: got %b want 1", bus.ovf); end
        for (int n = 0; n < 4; n++) got1[n] = got[n];
        recv_words();
      end
    join
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (got1[n] !== E_OVF[n]) begin n_bad++; $display("FAIL b2b_p1_res%0d: got %h want %h", n, got1[n], E_OVF[n]); end
      n_cmp++;
      if (got[n] !== E_BASIC[n]) begin n_bad++; $display("FAIL b2b_p2_res%0d: got %h want %h", n, got[n], E_BASIC[n]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
